// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_pkg;

  // Arbitration state: NORMAL favours the load path (B), FORCE_A lets
  // a starved ALU result (A) through for exactly one cycle.
  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_FORCE_A = 1'b1
  } arb_state_e;

  // Grant source encoding as seen on Grant_Src.
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle for both requesters (A = ALU, B = load).
// Latency: n/a (wires only).
// Backpressure: Ready is driven by the arbiter; a requester holds Valid/Addr/Data until Ready.
// Ports: master = requester side (drives Valid/Addr/Data), slave = arbiter side (drives Ready).
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = wb_pkg::DEF_DATA_W,
  parameter int ADDR_W = wb_pkg::DEF_ADDR_W
);
  logic              Req_A_Valid;
  logic [ADDR_W-1:0] Req_A_Addr;
  logic [DATA_W-1:0] Req_A_Data;
  logic              Req_A_Ready;

  logic              Req_B_Valid;
  logic [ADDR_W-1:0] Req_B_Addr;
  logic [DATA_W-1:0] Req_B_Data;
  logic              Req_B_Ready;

  modport master (
    output Req_A_Valid, Req_A_Addr, Req_A_Data,
    output Req_B_Valid, Req_B_Addr, Req_B_Data,
    input  Req_A_Ready, Req_B_Ready
  );

  modport slave (
    input  Req_A_Valid, Req_A_Addr, Req_A_Data,
    input  Req_B_Valid, Req_B_Addr, Req_B_Data,
    output Req_A_Ready, Req_B_Ready
  );
endinterface

// File: rtl/regfile_wb_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Latency: 1 cycle from enable to updated count.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clk, clr (sync, active-high), en, cnt (current value).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-way arbiter sharing the register file write port between ALU (A) and load (B) results.
// Latency: 1 cycle from handshake to Wr_En/Write_*_Port_1.
// Backpressure: B wins by default; A is forced through after STARVE_LIMIT refused cycles. Output never stalls.
// Ports: Clk_Core, Rst_Core (sync, active-high), req (slave side of the request bundle),
//        Wr_En/Write_Addr_Port_1/Write_Data_Port_1/Grant_Src (registered), Conflict_Cnt (saturating).
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic                 Clk_Core,
  input  logic                 Rst_Core,
  regfile_wb_arbiter_if.slave  req,
  output logic                 Wr_En,
  output logic [ADDR_W-1:0]    Write_Addr_Port_1,
  output logic [DATA_W-1:0]    Write_Data_Port_1,
  output logic                 Grant_Src,
  output logic [CNT_W-1:0]     Conflict_Cnt
);

  // Count value at which one more refusal would hit the limit.
  localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);

  arb_state_e        state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              grant_src_q, grant_src_d;

  logic rdy_a, rdy_b;
  logic grant_a, grant_b;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    wr_en_d     = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    grant_src_d = grant_src_q;
    rdy_a       = 1'b0;
    rdy_b       = 1'b0;

    // Ready looks only at the other side's Valid, so no Valid->Ready loop.
    if (!Rst_Core) begin
      unique case (state_q)
        ST_NORMAL: begin
          rdy_b = 1'b1;
          rdy_a = !req.Req_B_Valid;
        end
        ST_FORCE_A: begin
          rdy_a = 1'b1;
          rdy_b = !req.Req_A_Valid;
        end
      endcase
    end

    grant_a = req.Req_A_Valid && rdy_a;
    grant_b = req.Req_B_Valid && rdy_b;

    // FORCE_A lasts one cycle regardless of A, so a dropped A Valid cannot hang it.
    if (state_q == ST_FORCE_A) begin
      state_d = ST_NORMAL;
    end

    if (!req.Req_A_Valid || grant_a) begin
      starve_d = 4'd0;
    end else if (starve_q == STARVE_LAST) begin
      starve_d = 4'd0;
      state_d  = ST_FORCE_A;
    end else begin
      starve_d = starve_q + 4'd1;
    end

    // Register 0 is hardwired: the grant is still recorded but no write fires.
    if (grant_a) begin
      wr_en_d     = |req.Req_A_Addr;
      addr_d      = req.Req_A_Addr;
      data_d      = req.Req_A_Data;
      grant_src_d = SRC_A;
    end else if (grant_b) begin
      wr_en_d     = |req.Req_B_Addr;
      addr_d      = req.Req_B_Addr;
      data_d      = req.Req_B_Data;
      grant_src_d = SRC_B;
    end
  end

  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      state_q     <= ST_NORMAL;
      starve_q    <= 4'd0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      grant_src_q <= SRC_A;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      grant_src_q <= grant_src_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_conflict_cnt (
    .clk (Clk_Core),
    .clr (Rst_Core),
    .en  (req.Req_A_Valid && req.Req_B_Valid),
    .cnt (Conflict_Cnt)
  );

  assign req.Req_A_Ready  = rdy_a;
  assign req.Req_B_Ready  = rdy_b;
  assign Wr_En             = wr_en_q;
  assign Write_Addr_Port_1 = addr_q;
  assign Write_Data_Port_1 = data_q;
  assign Grant_Src         = grant_src_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic, scoreboarded against a reference model.
// Latency: expected outputs are queued per cycle and compared one edge later.
// Backpressure: stimulus holds each request until the arbiter accepts it.
module tb_regfile_wb_arbiter;

  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 5;
  localparam int STARVE_LIMIT = 4;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  typedef struct {
    logic              wr;
    logic              src;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  logic clk;
  logic rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              grant_src;
  logic [CNT_W-1:0]  conflict_cnt;

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)
  ) dut (
    .Clk_Core          (clk),
    .Rst_Core          (rst),
    .req               (bus),
    .Wr_En             (wr_en),
    .Write_Addr_Port_1 (wr_addr),
    .Write_Data_Port_1 (wr_data),
    .Grant_Src         (grant_src),
    .Conflict_Cnt      (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  exp_t exp_q[$];

  // Reference model state: how long A has been waiting, plus the last written values.
  int                m_wait;
  int                m_cnt;
  logic              m_src;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  bit                acc_a, acc_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Evaluate one cycle: inputs were applied at the preceding negedge.
  task automatic eval();
    bit   exp_ra, exp_rb, a_first, ga, gb;
    exp_t e;
    #1;
    if (rst) begin
      exp_ra = 1'b0;
      exp_rb = 1'b0;
    end else begin
      // A gets precedence once it has been turned away STARVE_LIMIT times in a row.
      a_first = (m_wait >= STARVE_LIMIT);
      exp_ra  = a_first ? 1'b1 : !bus.Req_B_Valid;
      exp_rb  = a_first ? !bus.Req_A_Valid : 1'b1;
    end
    check("ready_a", {31'd0, bus.Req_A_Ready}, {31'd0, exp_ra});
    check("ready_b", {31'd0, bus.Req_B_Ready}, {31'd0, exp_rb});
    ga    = bus.Req_A_Valid && exp_ra;
    gb    = bus.Req_B_Valid && exp_rb;
    acc_a = ga;
    acc_b = gb;
    e.wr  = 1'b0;
    if (rst) begin
      m_wait = 0;
      m_cnt  = 0;
      m_src  = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else begin
      if (ga) begin
        m_src = 1'b0; m_addr = bus.Req_A_Addr; m_data = bus.Req_A_Data;
        e.wr  = (bus.Req_A_Addr != 0);
      end else if (gb) begin
        m_src = 1'b1; m_addr = bus.Req_B_Addr; m_data = bus.Req_B_Data;
        e.wr  = (bus.Req_B_Addr != 0);
      end
      if (bus.Req_A_Valid && !ga) m_wait++;
      else m_wait = 0;
      if (bus.Req_A_Valid && bus.Req_B_Valid && m_cnt < CNT_MAX) m_cnt++;
    end
    e.src  = m_src;
    e.addr = m_addr;
    e.data = m_data;
    e.cnt  = CNT_W'(m_cnt);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: one registered result per edge, compared against the oldest prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("wr_en", {31'd0, wr_en}, {31'd0, e.wr});
      check("grant_src", {31'd0, grant_src}, {31'd0, e.src});
      check("conflict_cnt", {28'd0, conflict_cnt}, {28'd0, e.cnt});
      if (e.wr) begin
        check("wr_addr", {27'd0, wr_addr}, {27'd0, e.addr});
        check("wr_data", wr_data, e.data);
      end
    end
  end

  task automatic reload_random();
    if (!bus.Req_A_Valid || acc_a) begin
      bus.Req_A_Valid = ($urandom_range(0, 3) != 0);
      bus.Req_A_Addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.Req_A_Data  = $urandom;
    end
    if (!bus.Req_B_Valid || acc_b) begin
      bus.Req_B_Valid = ($urandom_range(0, 2) != 0);
      bus.Req_B_Addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.Req_B_Data  = $urandom;
    end
  endtask

  initial begin
    int a_grant_idx;

    // Reset held for three cycles with both requesters already valid.
    rst = 1'b1;
    bus.Req_A_Valid = 1'b1; bus.Req_A_Addr = 5'd7; bus.Req_A_Data = 32'hAAAA_0007;
    bus.Req_B_Valid = 1'b1; bus.Req_B_Addr = 5'd9; bus.Req_B_Data = 32'hBBBB_0009;
    m_wait = 0; m_cnt = 0; m_src = 1'b0; m_addr = '0; m_data = '0;
    repeat (3) eval();
    rst = 1'b0;
    for (int i = 0; i < 10 && (bus.Req_A_Valid || bus.Req_B_Valid); i++) begin
      eval();
      if (acc_a) bus.Req_A_Valid = 1'b0;
      if (acc_b) bus.Req_B_Valid = 1'b0;
    end
    eval();

    // Lone A request.
    bus.Req_A_Valid = 1'b1; bus.Req_A_Addr = 5'd5; bus.Req_A_Data = 32'hDEAD_BEEF;
    eval();
    bus.Req_A_Valid = 1'b0;
    eval();

    // Starvation: A waits behind a stream of B writes to regs 1..8.
    bus.Req_A_Valid = 1'b1; bus.Req_A_Addr = 5'd3; bus.Req_A_Data = 32'hA5A5_0003;
    bus.Req_B_Valid = 1'b1; bus.Req_B_Addr = 5'd1; bus.Req_B_Data = 32'hB000_0001;
    a_grant_idx = -1;
    for (int i = 0; i < 12; i++) begin
      eval();
      if (acc_a) begin
        if (a_grant_idx < 0) a_grant_idx = i;
        bus.Req_A_Valid = 1'b0;
      end
      if (acc_b) begin
        if (bus.Req_B_Addr == 5'd8) bus.Req_B_Valid = 1'b0;
        else begin
          bus.Req_B_Addr = bus.Req_B_Addr + 5'd1;
          bus.Req_B_Data = 32'hB000_0000 | 32'(bus.Req_B_Addr);
        end
      end
    end
    check("starve_grant_cycle", 32'(a_grant_idx), 32'd4);
    bus.Req_A_Valid = 1'b0; bus.Req_B_Valid = 1'b0;
    eval();

    // Register 0 from B: accepted, no write, source still recorded.
    bus.Req_B_Valid = 1'b1; bus.Req_B_Addr = 5'd0; bus.Req_B_Data = 32'h0000_1234;
    eval();
    bus.Req_B_Valid = 1'b0;
    eval();

    // Both valid for 20 cycles drives the 4-bit conflict count into saturation.
    bus.Req_A_Valid = 1'b1; bus.Req_B_Valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      eval();
      if (acc_a) begin bus.Req_A_Addr = 5'($urandom_range(1, 31)); bus.Req_A_Data = $urandom; end
      if (acc_b) begin bus.Req_B_Addr = 5'($urandom_range(1, 31)); bus.Req_B_Data = $urandom; end
    end
    check("conflict_saturated", {28'd0, conflict_cnt}, CNT_MAX);
    bus.Req_A_Valid = 1'b0; bus.Req_B_Valid = 1'b0;
    eval();

    // Reset right after an A handshake.
    bus.Req_A_Valid = 1'b1; bus.Req_A_Addr = 5'd12; bus.Req_A_Data = 32'h1200_00CC;
    eval();
    bus.Req_A_Valid = 1'b0;
    rst = 1'b1;
    eval();
    rst = 1'b0;
    eval();

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      reload_random();
      rst = ($urandom_range(0, 99) == 0);
      eval();
    end
    rst = 1'b0;
    bus.Req_A_Valid = 1'b0; bus.Req_B_Valid = 1'b0;
    repeat (2) eval();

    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
